// File: rtl/tone_pwm_gen.sv
// Tone generator: square wave at the note pitch, gated by a PWM carrier for volume.
// The tone period is re-sampled only at half-cycle boundaries, so note changes are glitch-free.
//
// state | meaning
// IDLE  | silent, amplifier off, prescaler/tick counters held at zero
// PLAY  | square wave running; period/sd evaluated only at half-cycle boundaries
module tone_pwm_gen #(
  parameter int PRESCALE  = 500,
  parameter int CARRIER_W = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [11:0]          period,
  input  logic                 sd,
  input  logic [CARRIER_W-1:0] vol,
  output logic                 pwm,
  output logic                 aud_en,
  output logic                 phase,
  output logic                 half_done
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]     PRE_ONE  = PRE_W'(1);
  localparam logic [CARRIER_W-1:0] CAR_ONE  = CARRIER_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t               state_q;
  logic [PRE_W-1:0]     pre_cnt_q;
  logic [11:0]          tick_cnt_q;
  logic [11:0]          cur_per_q;
  logic [CARRIER_W-1:0] car_cnt_q;
  logic                 phase_q;
  logic                 aud_en_q;
  logic                 half_done_q;
  logic                 pwm_q;

  logic tick;
  logic boundary;
  logic pwm_d;

  assign tick     = (state_q == ST_PLAY) && (pre_cnt_q == PRE_LAST);
  // cur_per_q is never zero in PLAY, so the subtraction cannot wrap there
  assign boundary = tick && (tick_cnt_q == (cur_per_q - 12'd1));
  assign pwm_d    = phase_q & aud_en_q & (car_cnt_q < vol);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      cur_per_q   <= '0;
      car_cnt_q   <= '0;
      phase_q     <= 1'b0;
      aud_en_q    <= 1'b0;
      half_done_q <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      car_cnt_q   <= car_cnt_q + CAR_ONE;
      pwm_q       <= pwm_d;
      half_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pre_cnt_q  <= '0;
          tick_cnt_q <= '0;
          phase_q    <= 1'b0;
          aud_en_q   <= 1'b0;
          if (sd && (period != 12'd0)) begin
            cur_per_q <= period;
            phase_q   <= 1'b1;
            aud_en_q  <= 1'b1;
            state_q   <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          pre_cnt_q <= tick ? '0 : (pre_cnt_q + PRE_ONE);
          if (boundary) begin
            tick_cnt_q  <= '0;
            half_done_q <= 1'b1;
            cur_per_q   <= period;
            if (!sd || (period == 12'd0)) begin
              phase_q  <= 1'b0;
              aud_en_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              phase_q <= ~phase_q;
            end
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 12'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pwm       = pwm_q;
  assign aud_en    = aud_en_q;
  assign phase     = phase_q;
  assign half_done = half_done_q;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// Bench for tone_pwm_gen: expected half-cycle boundaries are queued by the stimulus
// and matched by an independent monitor; levels and PWM duty are checked directly.
module tb_tone_pwm_gen;

  logic        clk;
  logic        rstn;
  logic [11:0] period;
  logic        sd;
  logic [2:0]  vol;
  logic        pwm;
  logic        aud_en;
  logic        phase;
  logic        half_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int   cyc;
    logic ph;
    logic aud;
  } exp_t;

  exp_t exp_q[$];

  tone_pwm_gen #(
    .PRESCALE (4),
    .CARRIER_W(3)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .period   (period),
    .sd       (sd),
    .vol      (vol),
    .pwm      (pwm),
    .aud_en   (aud_en),
    .phase    (phase),
    .half_done(half_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic p, input logic a);
    exp_t e;
    e.cyc = c;
    e.ph  = p;
    e.aud = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (pwm === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  // Monitor: every half_done pulse must match the oldest queued boundary.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL half_done_missing expected_cyc=%0d actual_none_by=%0d", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (half_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL half_done_unexpected actual_cyc=%0d expected=none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hd_cyc", cyc, e.cyc);
        chk("hd_phase", {31'd0, phase}, {31'd0, e.ph});
        chk("hd_aud_en", {31'd0, aud_en}, {31'd0, e.aud});
      end
    end
  end

  initial begin
    int s;
    int hi;
    rstn   = 1'b0;
    sd     = 1'b0;
    period = 12'd3;
    vol    = 3'd7;
    wait_n(3);
    chk("rst_pwm", {31'd0, pwm}, 0);
    chk("rst_aud_en", {31'd0, aud_en}, 0);
    chk("rst_phase", {31'd0, phase}, 0);
    chk("rst_half_done", {31'd0, half_done}, 0);

    // period 3: 12-clock half-cycles from the start edge at s+1
    rstn = 1'b1;
    sd   = 1'b1;
    s    = cyc;
    push(s + 13, 1'b0, 1'b1);
    push(s + 25, 1'b1, 1'b1);
    push(s + 37, 1'b0, 1'b1);
    wait_n(1);
    chk("start_phase", {31'd0, phase}, 1);
    chk("start_aud_en", {31'd0, aud_en}, 1);
    wait_n(2);
    count_pwm(8, hi);
    chk("pwm_vol7_phase1", hi, 7);
    wait_n(4);
    count_pwm(8, hi);
    chk("pwm_phase0", hi, 0);

    // period change 5 clocks into the half-cycle starting at s+25
    wait_n(7);
    period = 12'd5;
    push(s + 57, 1'b1, 1'b1);
    // sd drop 2 clocks into the half-cycle starting at s+57
    wait_n(29);
    sd = 1'b0;
    push(s + 77, 1'b0, 1'b0);
    wait_n(21);
    chk("stop_phase", {31'd0, phase}, 0);
    chk("stop_aud_en", {31'd0, aud_en}, 0);
    chk("stop_pwm", {31'd0, pwm}, 0);
    wait_n(20);

    // sd glitch low mid half-cycle, then period=1
    s      = cyc;
    period = 12'd3;
    sd     = 1'b1;
    push(s + 13, 1'b0, 1'b1);
    push(s + 25, 1'b1, 1'b1);
    wait_n(3);
    sd = 1'b0;
    wait_n(3);
    sd = 1'b1;
    wait_n(20);
    period = 12'd1;
    push(s + 37, 1'b0, 1'b1);
    push(s + 41, 1'b1, 1'b1);
    wait_n(16);
    sd = 1'b0;
    push(s + 45, 1'b0, 1'b0);
    wait_n(8);

    // period 0 with sd=1 must not start
    period = 12'd0;
    sd     = 1'b1;
    wait_n(20);
    chk("per0_phase", {31'd0, phase}, 0);
    chk("per0_aud_en", {31'd0, aud_en}, 0);
    chk("per0_pwm", {31'd0, pwm}, 0);

    // period 2, vol 0 then vol 4, then reset mid-note
    s      = cyc;
    period = 12'd2;
    vol    = 3'd0;
    push(s + 9, 1'b0, 1'b1);
    push(s + 17, 1'b1, 1'b1);
    push(s + 25, 1'b0, 1'b1);
    wait_n(2);
    count_pwm(12, hi);
    chk("pwm_vol0", hi, 0);
    vol = 3'd4;
    wait_n(4);
    count_pwm(8, hi);
    chk("pwm_vol4_phase1", hi, 4);
    wait_n(2);
    rstn = 1'b0;
    wait_n(1);
    chk("midrst_pwm", {31'd0, pwm}, 0);
    chk("midrst_aud_en", {31'd0, aud_en}, 0);
    chk("midrst_phase", {31'd0, phase}, 0);
    chk("midrst_half_done", {31'd0, half_done}, 0);
    rstn = 1'b1;
    wait_n(1);
    chk("restart_phase", {31'd0, phase}, 1);
    chk("restart_aud_en", {31'd0, aud_en}, 1);
    sd = 1'b0;
    push(s + 38, 1'b0, 1'b0);
    wait_n(12);

    // maximum period: 4*4095 = 16380 clocks per half-cycle
    s      = cyc;
    period = 12'd4095;
    sd     = 1'b1;
    push(s + 16381, 1'b0, 1'b0);
    wait_n(2);
    sd = 1'b0;
    wait_n(16385);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
